// File: rtl/display_source_scheduler_pkg.sv
// Shared constants, FSM encoding and small helpers for the display source scheduler.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package display_source_scheduler_pkg;

    localparam int N_SRC = 3;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd1,
        ST_CONV  = 2'd2,
        ST_ENC   = 2'd3
    } state_e;

    localparam logic [2:0] CONV_LAST = 3'd7;

    function automatic logic [1:0] src_inc(input logic [1:0] s);
        return (s >= 2'(N_SRC - 1)) ? 2'd0 : s + 2'd1;
    endfunction

    // Next valid source after cur (wrapping); cur itself if no other source is valid.
    function automatic logic [1:0] next_valid_src(input logic [1:0] cur, input logic [2:0] vld);
        logic [1:0] c1;
        logic [1:0] c2;
        c1 = src_inc(cur);
        c2 = src_inc(c1);
        if (vld[c1])
            return c1;
        else if (vld[c2])
            return c2;
        else
            return cur;
    endfunction

    function automatic logic [11:0] dabble_adjust(input logic [11:0] b);
        logic [11:0] r;
        for (int i = 0; i < 3; i++) begin
            r[i*4 +: 4] = (b[i*4 +: 4] >= 4'd5) ? b[i*4 +: 4] + 4'd3 : b[i*4 +: 4];
        end
        return r;
    endfunction

endpackage

// File: rtl/display_source_scheduler_if.sv
// Source inputs and display outputs of the scheduler, bundled for port connection.
interface display_source_scheduler_if;
    logic [23:0] src_data;
    logic [2:0]  src_valid;
    logic        mode_auto;
    logic        sel_step;
    logic [6:0]  pattern_3;
    logic [6:0]  pattern_2;
    logic [6:0]  pattern_1;
    logic [6:0]  pattern_0;
    logic [1:0]  active_src;
    logic        busy;

    modport master (
        output src_data, src_valid, mode_auto, sel_step,
        input  pattern_3, pattern_2, pattern_1, pattern_0, active_src, busy
    );

    modport slave (
        input  src_data, src_valid, mode_auto, sel_step,
        output pattern_3, pattern_2, pattern_1, pattern_0, active_src, busy
    );
endinterface

// File: rtl/display_source_scheduler_seg7_encoder.sv
// Combinational BCD digit to active-low 7-segment code; non-decimal codes show blank.
// Zero latency, no flow control.
module display_source_scheduler_seg7_encoder
    import display_source_scheduler_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);
    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/display_source_scheduler.sv
// Picks one of three signed 8-bit sources and renders it as sign + 3 decimal digits.
// 10 edges from leaving IDLE to new patterns; triggers during a conversion coalesce into one rerun.
module display_source_scheduler
    import display_source_scheduler_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = 100_000_000
) (
    input  logic                      clk,
    input  logic                      reset,
    display_source_scheduler_if.slave bus
);
    localparam int unsigned   CW         = $clog2(DWELL_CYCLES);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);

    // ---------------- source selection ----------------
    logic [1:0]    active_q, active_d;
    logic [CW-1:0] dwell_q, dwell_d;
    logic          mode_q;
    logic [7:0]    sel_dat;
    logic          sel_vld;
    logic          expire;
    logic          mode_chg;

    always_comb begin
        sel_dat = bus.src_data[23:16];
        case (active_q)
            2'd0:    sel_dat = bus.src_data[7:0];
            2'd1:    sel_dat = bus.src_data[15:8];
            default: sel_dat = bus.src_data[23:16];
        endcase
        sel_vld = bus.src_valid[active_q];
    end

    always_comb begin
        mode_chg = bus.mode_auto != mode_q;
        expire   = bus.mode_auto && !mode_chg && (dwell_q == DWELL_LAST);
        active_d = active_q;
        dwell_d  = dwell_q + CW'(1);
        if (mode_chg || !bus.mode_auto || bus.sel_step || expire)
            dwell_d = '0;
        // A step and an expiry in the same cycle produce one advance.
        if (bus.sel_step || expire)
            active_d = next_valid_src(active_q, bus.src_valid);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_q <= 2'd0;
            dwell_q  <= '0;
            mode_q   <= 1'b0;
        end else begin
            active_q <= active_d;
            dwell_q  <= dwell_d;
            mode_q   <= bus.mode_auto;
        end
    end

    // ---------------- conversion trigger ----------------
    logic [10:0] key_q, key_d;
    logic        first_q;
    logic        pending_q, pending_d;
    logic        trigger;
    logic        consume;

    assign key_d   = {sel_vld, active_q, sel_dat};
    assign trigger = first_q || (key_d != key_q);
    // A new trigger wins over the clear so nothing arriving while a run starts is lost.
    assign pending_d = trigger || (pending_q && !consume);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_q     <= '0;
            first_q   <= 1'b1;
            pending_q <= 1'b0;
        end else begin
            key_q     <= key_d;
            first_q   <= 1'b0;
            pending_q <= pending_d;
        end
    end

    // ---------------- conversion FSM ----------------
    state_e     state_q, state_d;
    logic [2:0] iter_q, iter_d;
    logic       do_latch, do_conv, do_enc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (pending_q) state_d = ST_LATCH;
            ST_LATCH: state_d = ST_CONV;
            ST_CONV:  if (iter_q == CONV_LAST) state_d = ST_ENC;
            ST_ENC:   state_d = pending_q ? ST_LATCH : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        do_latch = state_q == ST_LATCH;
        do_conv  = state_q == ST_CONV;
        do_enc   = state_q == ST_ENC;
        bus.busy = state_q != ST_IDLE;
        // ENC hands straight to LATCH on a pending rerun, so busy never drops in between.
        consume  = pending_q && (state_q == ST_IDLE || state_q == ST_ENC);
    end

    // ---------------- double-dabble datapath ----------------
    logic        neg_q, neg_d;
    logic        vld_q, vld_d;
    logic [7:0]  sh_q, sh_d;
    logic [11:0] bcd_q, bcd_d;

    always_comb begin
        neg_d  = neg_q;
        vld_d  = vld_q;
        sh_d   = sh_q;
        bcd_d  = bcd_q;
        iter_d = iter_q;
        if (do_latch) begin
            neg_d  = sel_dat[7];
            vld_d  = sel_vld;
            sh_d   = sel_dat[7] ? (8'd0 - sel_dat) : sel_dat;
            bcd_d  = '0;
            iter_d = 3'd0;
        end else if (do_conv) begin
            {bcd_d, sh_d} = {dabble_adjust(bcd_q), sh_q} << 1;
            iter_d        = iter_q + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            neg_q  <= 1'b0;
            vld_q  <= 1'b0;
            sh_q   <= '0;
            bcd_q  <= '0;
            iter_q <= 3'd0;
        end else begin
            neg_q  <= neg_d;
            vld_q  <= vld_d;
            sh_q   <= sh_d;
            bcd_q  <= bcd_d;
            iter_q <= iter_d;
        end
    end

    // ---------------- pattern encode ----------------
    logic [6:0] seg_h, seg_t, seg_u;
    logic [6:0] pat3_q, pat2_q, pat1_q, pat0_q;
    logic [6:0] pat3_d, pat2_d, pat1_d, pat0_d;
    logic       h_zero, t_zero;

    display_source_scheduler_seg7_encoder u_enc_h (.bcd_i(bcd_q[11:8]), .seg_o(seg_h));
    display_source_scheduler_seg7_encoder u_enc_t (.bcd_i(bcd_q[7:4]),  .seg_o(seg_t));
    display_source_scheduler_seg7_encoder u_enc_u (.bcd_i(bcd_q[3:0]),  .seg_o(seg_u));

    assign h_zero = bcd_q[11:8] == 4'd0;
    assign t_zero = bcd_q[7:4] == 4'd0;

    always_comb begin
        pat3_d = pat3_q;
        pat2_d = pat2_q;
        pat1_d = pat1_q;
        pat0_d = pat0_q;
        if (do_enc) begin
            if (!vld_q) begin
                pat3_d = SEG_MINUS;
                pat2_d = SEG_MINUS;
                pat1_d = SEG_MINUS;
                pat0_d = SEG_MINUS;
            end else begin
                pat3_d = neg_q ? SEG_MINUS : SEG_BLANK;
                pat2_d = h_zero ? SEG_BLANK : seg_h;
                pat1_d = (h_zero && t_zero) ? SEG_BLANK : seg_t;
                pat0_d = seg_u;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat3_q <= SEG_BLANK;
            pat2_q <= SEG_BLANK;
            pat1_q <= SEG_BLANK;
            pat0_q <= SEG_BLANK;
        end else begin
            pat3_q <= pat3_d;
            pat2_q <= pat2_d;
            pat1_q <= pat1_d;
            pat0_q <= pat0_d;
        end
    end

    assign bus.pattern_3  = pat3_q;
    assign bus.pattern_2  = pat2_q;
    assign bus.pattern_1  = pat1_q;
    assign bus.pattern_0  = pat0_q;
    assign bus.active_src = active_q;

endmodule

// File: tb/tb_display_source_scheduler.sv
// Scoreboard bench: expected display words are queued when stimulus is applied and
// popped whenever the four patterns change.
module tb_display_source_scheduler;
    localparam logic [31:0] BLANK4 = 32'h0FFF_FFFF;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    logic [31:0] sb[$];
    logic [31:0] last_pat = BLANK4;

    display_source_scheduler_if bus ();

    display_source_scheduler #(.DWELL_CYCLES(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // Reference: plain integer arithmetic, independent of the shift-and-add datapath.
    function automatic logic [31:0] exp_pat(input logic [7:0] v, input logic vld);
        int s, m, h, t, u;
        logic [6:0] p3, p2, p1, p0;
        if (!vld) return {4'h0, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
        s  = int'($signed(v));
        m  = (s < 0) ? -s : s;
        h  = m / 100;
        t  = (m / 10) % 10;
        u  = m % 10;
        p3 = (s < 0) ? 7'h3F : 7'h7F;
        p2 = (h == 0) ? 7'h7F : seg(h);
        p1 = (h == 0 && t == 0) ? 7'h7F : seg(t);
        p0 = seg(u);
        return {4'h0, p3, p2, p1, p0};
    endfunction

    function automatic logic [31:0] cur_pat();
        return {4'h0, bus.pattern_3, bus.pattern_2, bus.pattern_1, bus.pattern_0};
    endfunction

    always @(negedge clk) begin
        logic [31:0] cur;
        logic [31:0] e;
        if (reset) begin
            last_pat = BLANK4;
        end else begin
            cur = cur_pat();
            if (cur != last_pat) begin
                if (sb.size() == 0) begin
                    chk("unexpected_update", cur, last_pat);
                end else begin
                    e = sb.pop_front();
                    chk("pattern", cur, e);
                end
                last_pat = cur;
            end
        end
    end

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(tag, 32'(sb.size()), 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1 bus.sel_step = 1'b1;
        @(posedge clk);
        #1 bus.sel_step = 1'b0;
    endtask

    task automatic set_src(input int idx, input logic [7:0] v);
        @(posedge clk);
        #1 bus.src_data[idx*8 +: 8] = v;
    endtask

    task automatic wait_busy(input string tag);
        int n;
        n = 0;
        while (!bus.busy && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(bus.busy), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, gaps, n, k, c;
        int t_sw[3];
        logic [1:0] prev;
        logic [7:0] vals[3];

        vals[0] = 8'd42;
        vals[1] = 8'h80;
        vals[2] = 8'hFF;
        bus.src_data  = {vals[2], vals[1], vals[0]};
        bus.src_valid = 3'b111;
        bus.mode_auto = 1'b0;
        bus.sel_step  = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_pat", cur_pat(), BLANK4);
        chk("rst_active", 32'(bus.active_src), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);

        // First conversion after release, with latency measured from busy rising
        sb.push_back(exp_pat(vals[0], 1'b1));
        @(posedge clk);
        #1 reset = 1'b0;
        wait_busy("first_busy");
        lat = 0;
        while (cur_pat() == BLANK4 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'd10);
        wait_drain("drain_first", 40);
        chk("idle_busy", 32'(bus.busy), 32'd0);

        // Blanking boundaries on source 0
        sb.push_back(exp_pat(8'd100, 1'b1)); set_src(0, 8'd100); wait_drain("drain_100", 40);
        sb.push_back(exp_pat(8'd0, 1'b1));   set_src(0, 8'd0);   wait_drain("drain_0", 40);
        sb.push_back(exp_pat(8'd127, 1'b1)); set_src(0, 8'd127); wait_drain("drain_127", 40);
        sb.push_back(exp_pat(8'd42, 1'b1));  set_src(0, 8'd42);  wait_drain("drain_42", 40);

        // Manual stepping through all sources
        for (int i = 1; i <= 3; i++) begin
            sb.push_back(exp_pat(vals[i % 3], 1'b1));
            step();
            wait_drain("drain_step", 40);
            chk("step_active", 32'(bus.active_src), 32'(i % 3));
        end

        // Invalid source 1 is skipped
        @(posedge clk);
        #1 bus.src_valid = 3'b101;
        sb.push_back(exp_pat(vals[2], 1'b1));
        step();
        wait_drain("drain_skip", 40);
        chk("skip_active", 32'(bus.active_src), 32'd2);
        sb.push_back(exp_pat(vals[0], 1'b1));
        step();
        wait_drain("drain_wrap", 40);
        chk("wrap_active", 32'(bus.active_src), 32'd0);

        // Auto rotation, mid-dwell step, and step coinciding with expiry
        @(posedge clk);
        #1 bus.src_valid = 3'b111;
        for (int i = 0; i < 6; i++) sb.push_back(exp_pat(vals[(i + 1) % 3], 1'b1));
        @(posedge clk);
        #1 bus.mode_auto = 1'b1;
        prev = bus.active_src;
        k = 0;
        n = 0;
        while (k < 3 && n < 200) begin
            @(negedge clk);
            n++;
            if (bus.active_src != prev) begin
                chk("auto_order", 32'(bus.active_src), 32'((k + 1) % 3));
                t_sw[k] = n;
                prev = bus.active_src;
                k++;
            end
        end
        chk("auto_switches", 32'(k), 32'd3);
        chk("dwell_a", 32'(t_sw[1] - t_sw[0]), 32'd16);
        chk("dwell_b", 32'(t_sw[2] - t_sw[1]), 32'd16);
        repeat (5) @(posedge clk);
        #1 bus.sel_step = 1'b1;
        @(posedge clk);
        #1 bus.sel_step = 1'b0;
        @(negedge clk);
        chk("mid_step_active", 32'(bus.active_src), 32'd1);
        c = 0;
        while (bus.active_src == 2'd1 && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk("dwell_after_step", 32'(c), 32'd16);
        chk("auto_after_step", 32'(bus.active_src), 32'd2);
        repeat (15) @(posedge clk);
        #1 bus.sel_step = 1'b1;
        @(posedge clk);
        #1 bus.sel_step = 1'b0;
        bus.mode_auto = 1'b0;
        @(negedge clk);
        chk("step_on_expiry", 32'(bus.active_src), 32'd0);
        wait_drain("drain_auto", 80);
        chk("manual_hold", 32'(bus.active_src), 32'd0);

        // Data change during CONV: old value first, then an immediate rerun
        sb.push_back(exp_pat(8'd7, 1'b1));
        sb.push_back(exp_pat(8'd99, 1'b1));
        set_src(0, 8'd7);
        wait_busy("rerun_busy");
        repeat (3) @(posedge clk);
        #1 bus.src_data[7:0] = 8'd99;
        gaps = 0;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
            if (sb.size() != 0 && !bus.busy) gaps++;
        end
        chk("busy_gap", 32'(gaps), 32'd0);
        chk("drain_rerun", 32'(sb.size()), 32'd0);
        chk("rerun_idle", 32'(bus.busy), 32'd0);

        // Reset mid-conversion, then all sources invalid
        sb.push_back(exp_pat(vals[1], 1'b1));
        step();
        wait_drain("drain_pre_rst", 40);
        set_src(1, 8'd55);
        wait_busy("rst_conv_busy");
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("midrst_pat", cur_pat(), BLANK4);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_active", 32'(bus.active_src), 32'd0);
        bus.src_valid = 3'b000;
        sb.push_back(exp_pat(8'd0, 1'b0));
        @(posedge clk);
        #1 reset = 1'b0;
        wait_drain("drain_invalid", 40);
        chk("invalid_active", 32'(bus.active_src), 32'd0);
        repeat (5) @(negedge clk);
        chk("final_busy", 32'(bus.busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
